// File: rtl/regbr_pkg.sv
// Shared types for the native-register-to-APB bridge: FSM state encoding and
// request-qualifier helper.
package regbr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } regbr_state_e;

  // A request is legal only when it names exactly one direction.
  function automatic logic req_legal(input logic wr, input logic rd);
    return wr ^ rd;
  endfunction

endpackage

// File: rtl/regbr_timeout_cnt.sv
// ACCESS-phase watchdog for regbr_native2apb. Compiled only when
// REGBR_APB_TIMEOUT_EN is defined, so the default build carries no counter.
`ifdef REGBR_APB_TIMEOUT_EN
module regbr_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count equals the number of completed wait cycles, so the last allowed
  // cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign expired_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != CW'(TIMEOUT_CYCLES))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/regbr_native2apb.sv
// Single-outstanding bridge from a native register strobe interface to APB.
// Optional ACCESS-phase timeout enabled by defining REGBR_APB_TIMEOUT_EN.
module regbr_native2apb
  import regbr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  fsm_clk,
  input  logic                  fsm_rst,
  input  logic                  global_sync_reset_in,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ack_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  regbr_state_e          state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  ack_vld_q, ack_vld_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  ack_err_q, ack_err_d;
  logic                  tmo_expired;

`ifdef REGBR_APB_TIMEOUT_EN
  regbr_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i    (fsm_clk),
    .rst_i    (fsm_rst),
    .clr_i    ((state_q != ACCESS) || global_sync_reset_in),
    .en_i     (!PREADY),
    .expired_o(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_vld_d = 1'b0;
    rd_data_d = '0;
    ack_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_vld) begin
          if (req_legal(wr_en, rd_en)) begin
            state_d  = SETUP;
            psel_d   = 1'b1;
            paddr_d  = addr;
            pwdata_d = wr_data;
            pwrite_d = wr_en;
          end else begin
            // Malformed request never reaches the bus.
            state_d   = RESP;
            ack_vld_d = 1'b1;
            ack_err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_vld_d = 1'b1;
          ack_err_d = PSLVERR;
          rd_data_d = pwrite_q ? '0 : PRDATA;
        end else if (tmo_expired) begin
          state_d   = RESP;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_vld_d = 1'b1;
          ack_err_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Synchronous abort wins over everything, including a fresh request.
    if (global_sync_reset_in) begin
      state_d   = IDLE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      ack_vld_d = 1'b0;
      rd_data_d = '0;
      ack_err_d = 1'b0;
    end
  end

  always_ff @(posedge fsm_clk or posedge fsm_rst) begin
    if (fsm_rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_vld_q <= 1'b0;
      rd_data_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_vld_q <= ack_vld_d;
      rd_data_q <= rd_data_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign ack_vld = ack_vld_q;
  assign rd_data = rd_data_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_regbr_native2apb.sv
// Randomized bench for regbr_native2apb; expected bus timeline and response are
// derived per transaction from wait-state count, direction and slave response.
module tb_regbr_native2apb;

`ifdef REGBR_APB_TIMEOUT_EN
  localparam int TMO       = 4;
  localparam int MAX_WAITS = 3;
`else
  localparam int TMO       = 255;
  localparam int MAX_WAITS = 6;
`endif

  logic        fsm_clk = 1'b0;
  logic        fsm_rst;
  logic        global_sync_reset_in;
  logic        req_vld, wr_en, rd_en;
  logic [63:0] addr;
  logic [31:0] wr_data;
  logic        ack_vld, ack_err;
  logic [31:0] rd_data;
  logic        PSEL, PENABLE, PWRITE;
  logic [63:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;

  int n_chk = 0;
  int n_err = 0;

  always #5 fsm_clk = ~fsm_clk;

  regbr_native2apb #(
    .ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .fsm_clk(fsm_clk), .fsm_rst(fsm_rst), .global_sync_reset_in(global_sync_reset_in),
    .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .ack_vld(ack_vld), .rd_data(rd_data), .ack_err(ack_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge and follow it cycle by cycle. Cycle c is the
  // view after the c-th rising edge following the request.
  task automatic do_txn(input logic w, input logic r, input logic [63:0] a,
                        input logic [31:0] d, input int waits,
                        input logic [31:0] prd, input logic serr);
    logic        legal, exp_sel, exp_en;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    legal   = w ^ r;
    lat     = legal ? 3 + waits : 1;
    exp_rd  = (legal && r) ? prd : 32'h0;
    exp_err = legal ? serr : 1'b1;
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
    PRDATA = prd; PSLVERR = serr; PREADY = 1'b0;
    @(negedge fsm_clk);
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = {$urandom, $urandom}; wr_data = $urandom;
    for (int c = 1; c <= lat + 1; c++) begin
      exp_sel = legal && (c <= 2 + waits);
      exp_en  = legal && (c >= 2) && (c <= 2 + waits);
      chk("psel", PSEL, exp_sel);
      chk("penable", PENABLE, exp_en);
      chk("ack_vld", ack_vld, c == lat);
      if (exp_sel) begin
        chk("paddr", PADDR, a);
        chk("pwdata", PWDATA, d);
        chk("pwrite", PWRITE, w);
      end
      if (c == lat) begin
        chk("rd_data", rd_data, exp_rd);
        chk("ack_err", ack_err, exp_err);
      end else begin
        chk("rd_data_idle", rd_data, 0);
      end
      PREADY = legal && (c == 2 + waits);
      PRDATA = PREADY ? prd : $urandom;
      @(negedge fsm_clk);
    end
    PREADY = 1'b0;
  endtask

  initial begin
    fsm_rst = 1'b1; global_sync_reset_in = 1'b0;
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wr_data = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_ack", {ack_vld, ack_err, PWRITE}, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge fsm_clk);
    fsm_rst = 1'b0;
    @(negedge fsm_clk);

    do_txn(1, 0, 64'h10, 32'hA5A5_A5A5, 0, 32'h0BAD_F00D, 0);
    do_txn(0, 1, 64'h20, 32'h0, 3, 32'h1234_5678, 0);
    do_txn(0, 1, 64'h30, 32'h0, 1, 32'hCAFE_0001, 1);
    do_txn(1, 1, 64'h40, 32'h5555_AAAA, 0, 32'h0, 0);
    do_txn(0, 0, 64'h50, 32'h0, 0, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      int          sel;
      logic        w, r;
      sel = $urandom_range(0, 9);
      w = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      r = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : ~w;
      do_txn(w, r, {$urandom, $urandom}, $urandom, $urandom_range(0, MAX_WAITS),
             $urandom, 1'($urandom_range(0, 3) == 0));
    end

    // Stalled slave: timeout build gives up, default build waits.
    req_vld = 1'b1; rd_en = 1'b1; addr = 64'h60; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
    @(negedge fsm_clk);
    req_vld = 1'b0; rd_en = 1'b0;
`ifdef REGBR_APB_TIMEOUT_EN
    for (int c = 1; c <= 7; c++) begin
      chk("tmo_psel", PSEL, c <= 5);
      chk("tmo_penable", PENABLE, (c >= 2) && (c <= 5));
      chk("tmo_ack", ack_vld, c == 6);
      if (c == 6) begin
        chk("tmo_err", ack_err, 1);
        chk("tmo_rd_data", rd_data, 0);
      end
      @(negedge fsm_clk);
    end
`else
    for (int c = 1; c <= 30; c++) begin
      chk("stall_psel", PSEL, 1);
      chk("stall_penable", PENABLE, c >= 2);
      chk("stall_ack", ack_vld, 0);
      @(negedge fsm_clk);
    end
    PREADY = 1'b1;
    @(negedge fsm_clk);
    PREADY = 1'b0;
    chk("stall_done_ack", ack_vld, 1);
    chk("stall_done_rd", rd_data, 32'hDEAD_BEEF);
    @(negedge fsm_clk);
`endif

    // Asynchronous reset in ACCESS, asserted between clock edges.
    req_vld = 1'b1; rd_en = 1'b1; addr = 64'h70;
    @(negedge fsm_clk);
    req_vld = 1'b0; rd_en = 1'b0;
    @(negedge fsm_clk);
    chk("pre_rst_penable", PENABLE, 1);
    #2 fsm_rst = 1'b1;
    #1;
    chk("arst_psel", PSEL, 0);
    chk("arst_penable", PENABLE, 0);
    chk("arst_paddr", PADDR, 0);
    @(negedge fsm_clk);
    fsm_rst = 1'b0; PREADY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge fsm_clk);
      chk("arst_no_ack", ack_vld, 0);
      chk("arst_no_psel", PSEL, 0);
    end
    PREADY = 1'b0;
    do_txn(1, 0, 64'h80, 32'h1357_9BDF, 1, 32'h0, 0);

    // Synchronous abort in ACCESS, even with PREADY arriving that same cycle.
    req_vld = 1'b1; wr_en = 1'b1; addr = 64'h90; wr_data = 32'h2468_ACE0;
    @(negedge fsm_clk);
    req_vld = 1'b0; wr_en = 1'b0;
    @(negedge fsm_clk);
    global_sync_reset_in = 1'b1; PREADY = 1'b1;
    @(negedge fsm_clk);
    global_sync_reset_in = 1'b0; PREADY = 1'b0;
    chk("srst_psel", PSEL, 0);
    chk("srst_penable", PENABLE, 0);
    chk("srst_ack", ack_vld, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge fsm_clk);
      chk("srst_no_ack", ack_vld, 0);
    end
    do_txn(0, 1, 64'hA0, 32'h0, 0, 32'h8765_4321, 0);

    // Synchronous abort beats a simultaneous request in IDLE.
    req_vld = 1'b1; wr_en = 1'b1; addr = 64'hB0; global_sync_reset_in = 1'b1;
    @(negedge fsm_clk);
    req_vld = 1'b0; wr_en = 1'b0; global_sync_reset_in = 1'b0;
    chk("srst_req_psel", PSEL, 0);
    chk("srst_req_ack", ack_vld, 0);
    @(negedge fsm_clk);
    chk("srst_req_psel2", PSEL, 0);
    do_txn(1, 0, 64'hC0, 32'hFFFF_0000, 2, 32'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/regbr_native2apb.md
REGBR_NATIVE2APB -- requirements
Module: regbr_native2apb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, address width of reg_native_if and APB.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of reg_native_if and APB.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase cycles waiting for PREADY.
REQ-004 SHALL have port fsm_clk  input  1  single clock for all logic (also drives the APB side).
REQ-005 SHALL have port fsm_rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port global_sync_reset_in  input  1  synchronous abort to IDLE.
REQ-007 SHALL have port req_vld  input  1  upstream request strobe.
REQ-008 SHALL have port wr_en / rd_en  input  1 each  write / read qualifier.
REQ-009 SHALL have port addr  input  ADDR_WIDTH  request address.
REQ-010 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-011 SHALL have port ack_vld  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  read data, valid with ack_vld.
REQ-013 SHALL have port ack_err  output  1  error flag, valid with ack_vld.
REQ-014 SHALL have ports PSEL, PENABLE, PWRITE  output  1 each; PADDR  output  ADDR_WIDTH; PWDATA  output  DATA_WIDTH.
REQ-015 SHALL have ports PREADY, PSLVERR  input  1 each; PRDATA  input  DATA_WIDTH.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; all outputs registered.
REQ-017 SHALL, in IDLE, on req_vld=1 with exactly one of wr_en/rd_en set, latch addr, wr_data and direction into PADDR/PWDATA/PWRITE and enter SETUP on the next cycle.
REQ-018 SHALL drive PSEL=1, PENABLE=0 in SETUP for exactly one cycle, then enter ACCESS.
REQ-019 SHALL drive PSEL=1, PENABLE=1 in ACCESS, holding PADDR/PWDATA/PWRITE stable, until PREADY=1 is sampled.
REQ-020 SHALL, on PREADY=1 in ACCESS, capture PRDATA (reads only; writes capture 0) and PSLVERR, then enter RESP with PSEL=PENABLE=0.
REQ-021 SHALL assert ack_vld=1 for exactly the one RESP cycle, with rd_data = captured data and ack_err = captured PSLVERR; rd_data SHALL be 0 whenever ack_vld=0.
REQ-022 SHALL give zero-wait-state latency of 3 cycles: req_vld at cycle N, PSEL at N+1, PENABLE at N+2, ack_vld at N+3 when PREADY=1 at N+2.
REQ-023 SHALL ignore req_vld in any state other than IDLE (at most one outstanding request).
REQ-024 SHALL, on req_vld with both or neither of wr_en/rd_en set, issue no APB transfer and go directly to RESP with ack_err=1 and rd_data=0.
REQ-025 SHALL, on global_sync_reset_in=1, return to IDLE on the next edge, deassert PSEL/PENABLE, and emit no ack_vld; this SHALL override a simultaneous req_vld.

Reset
REQ-026 SHALL, while fsm_rst=1, force state IDLE and all outputs to 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, ack_vld, rd_data, ack_err), independent of fsm_clk.
REQ-027 SHALL abandon any in-flight transfer when reset is asserted mid-operation and SHALL NOT emit ack_vld after release.

Configuration
REQ-028 SHALL, with macro REGBR_APB_TIMEOUT_EN defined, count ACCESS cycles and, if PREADY has not been sampled high after TIMEOUT_CYCLES cycles, end the transfer (PSEL=PENABLE=0) and go to RESP with ack_err=1 and rd_data=0.
REQ-029 SHALL, without REGBR_APB_TIMEOUT_EN, wait in ACCESS indefinitely; no timeout counter SHALL be synthesized.

Structure
REQ-030 SHALL place the FSM state enum (IDLE/SETUP/ACCESS/RESP) in shared package regbr_pkg.
REQ-031 SHALL keep the timeout counter in sub-module regbr_timeout_cnt, instantiated only under REGBR_APB_TIMEOUT_EN; its counter width SHALL be $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-032 SHALL cover zero-wait write: req_vld, wr_en, addr=0x10, wr_data=0xA5A5A5A5 -> PSEL at N+1, PENABLE at N+2, PWDATA=0xA5A5A5A5, ack_vld at N+3, ack_err=0.
REQ-033 SHALL cover read with 3 wait states: PRDATA=0x12345678, PREADY high after 3 ACCESS cycles -> ack_vld one cycle later, rd_data=0x12345678.
REQ-034 SHALL cover PSLVERR=1 on a read -> ack_vld with ack_err=1.
REQ-035 SHALL cover illegal request (wr_en=rd_en=1) -> PSEL stays 0, ack_vld at N+1, ack_err=1, rd_data=0.
REQ-036 SHALL cover timeout with REGBR_APB_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, PREADY tied low -> ack_err=1 after 4 ACCESS cycles; without the macro, PSEL stays high.
REQ-037 SHALL cover fsm_rst and global_sync_reset_in asserted during ACCESS -> PSEL=0, no ack_vld, next request completes normally.
